zrle_encoder: RTL and testbench

//  Zero run-length encoder for the EBPC compressor. It takes a stream of zero/non-zero flags, one per

---
 rtl/ebpc_pkg.sv | 9 +
 rtl/zrle_encoder.sv | 117 +++++++++++
 tb/tb_zrle_encoder.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ebpc_pkg.sv
// Shared EBPC compressor constants: output word width and zero-run length field sizing.
package ebpc_pkg;

  localparam int DATA_W           = 8;
  localparam int LOG_DATA_W       = $clog2(DATA_W);
  localparam int LOG_MAX_ZRLE_LEN = 4;
  localparam int MAX_ZRLE_LEN     = 2 ** LOG_MAX_ZRLE_LEN;

endpackage

// File: rtl/zrle_encoder.sv
// Zero run-length encoder: packs '1' (non-zero) and '0'+(n-1) (zero run of n) symbols
// MSB-first into DATA_W-bit words, draining a zero-padded final word on flush.
module zrle_encoder
  import ebpc_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              znz_i,
  input  logic              vld_i,
  output logic              rdy_o,
  input  logic              flush_i,
  output logic [DATA_W-1:0] data_o,
  output logic              vld_o,
  output logic              last_o,
  input  logic              rdy_i
);

  typedef enum logic {ACTIVE, DRAIN} state_e;

  localparam int BUF_W = 2 * DATA_W;
  localparam int SYM_W = LOG_MAX_ZRLE_LEN + 1;

  localparam logic [LOG_DATA_W:0]       WORD_BITS = (LOG_DATA_W + 1)'(DATA_W);
  localparam logic [LOG_DATA_W:0]       SYM_BITS  = (LOG_DATA_W + 1)'(SYM_W);
  localparam logic [LOG_DATA_W:0]       ONE_BIT   = (LOG_DATA_W + 1)'(1);
  localparam logic [LOG_MAX_ZRLE_LEN:0] MAX_RUN   = (LOG_MAX_ZRLE_LEN + 1)'(MAX_ZRLE_LEN);

  state_e                    state_q, state_d;
  logic [BUF_W-1:0]          stream_q, stream_d;
  logic [LOG_DATA_W:0]       fill_q, fill_d;
  logic [LOG_MAX_ZRLE_LEN:0] run_q, run_d;
  logic [LOG_MAX_ZRLE_LEN:0] run_inc;
  logic                      pop, accept;

  // Left-align a len-bit symbol, then slide it down past the bits already buffered.
  function automatic logic [BUF_W-1:0] place(input logic [SYM_W-1:0] sym, input int len,
                                              input logic [LOG_DATA_W:0] pos);
    return (BUF_W'(sym) << (BUF_W - len)) >> pos;
  endfunction

  function automatic logic [SYM_W-1:0] run_sym(input logic [LOG_MAX_ZRLE_LEN:0] n);
    logic [LOG_MAX_ZRLE_LEN:0] m;
    m = n - 1'b1;
    return {1'b0, m[LOG_MAX_ZRLE_LEN-1:0]};
  endfunction

  assign data_o  = stream_q[BUF_W-1 -: DATA_W];
  assign vld_o   = (fill_q >= WORD_BITS) || (state_q == DRAIN && fill_q != '0);
  assign last_o  = vld_o && state_q == DRAIN && fill_q <= WORD_BITS;
  assign pop     = vld_o && rdy_i;
  assign rdy_o   = state_q == ACTIVE && (fill_q < WORD_BITS || pop);
  assign accept  = vld_i && rdy_o;
  assign run_inc = run_q + 1'b1;

  // Pop first so appends land behind whatever remains after the outgoing word.
  always_comb begin
    state_d  = state_q;
    stream_d = stream_q;
    fill_d   = fill_q;
    run_d    = run_q;

    if (pop) begin
      stream_d = stream_q << DATA_W;
      fill_d   = (fill_q >= WORD_BITS) ? fill_q - WORD_BITS : '0;
      if (state_q == DRAIN && fill_q <= WORD_BITS) begin
        state_d  = ACTIVE;
        fill_d   = '0;
        stream_d = '0;
      end
    end

    if (accept) begin
      if (!znz_i) begin
        if (run_inc == MAX_RUN) begin
          stream_d = stream_d | place(run_sym(run_inc), SYM_W, fill_d);
          fill_d   = fill_d + SYM_BITS;
          run_d    = '0;
        end else begin
          run_d = run_inc;
        end
      end else begin
        if (run_q != '0) begin
          stream_d = stream_d | place(run_sym(run_q), SYM_W, fill_d);
          fill_d   = fill_d + SYM_BITS;
        end
        stream_d = stream_d | place(SYM_W'(1), 1, fill_d);
        fill_d   = fill_d + ONE_BIT;
        run_d    = '0;
      end

      // A pending run must be committed before the tail is drained.
      if (flush_i) begin
        if (run_d != '0) begin
          stream_d = stream_d | place(run_sym(run_d), SYM_W, fill_d);
          fill_d   = fill_d + SYM_BITS;
        end
        run_d   = '0;
        state_d = DRAIN;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ACTIVE;
      stream_q <= '0;
      fill_q   <= '0;
      run_q    <= '0;
    end else begin
      state_q  <= state_d;
      stream_q <= stream_d;
      fill_q   <= fill_d;
      run_q    <= run_d;
    end
  end

endmodule

// File: tb/tb_zrle_encoder.sv
// Self-checking bench for zrle_encoder: directed corner streams plus random streams
// with random handshakes, checked against a symbol-level model and a decoder round trip.
module tb_zrle_encoder;
  import ebpc_pkg::*;

  logic              clk_i = 1'b0;
  logic              rst_ni, znz_i, vld_i, flush_i, rdy_i;
  logic              rdy_o, vld_o, last_o;
  logic [DATA_W-1:0] data_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DATA_W-1:0] got_data[$];
  bit                got_last[$];
  logic              s_vld, s_last, s_rdy;
  logic [DATA_W-1:0] s_data;
  bit                acc;
  bit                prev_stall = 0;
  logic [DATA_W-1:0] prev_data;
  logic              prev_last;
  int                stall_viol = 0;
  int                stall_seen = 0;

  zrle_encoder dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .znz_i  (znz_i),
    .vld_i  (vld_i),
    .rdy_o  (rdy_o),
    .flush_i(flush_i),
    .data_o (data_o),
    .vld_o  (vld_o),
    .last_o (last_o),
    .rdy_i  (rdy_i)
  );

  always #5 clk_i = ~clk_i;

  // One clock: drive at negedge, sample 1 ns later, record popped words and stall holds.
  task automatic drive_cycle(input bit v, input bit z, input bit f, input bit r);
    @(negedge clk_i);
    vld_i = v; znz_i = z; flush_i = f; rdy_i = r;
    #1;
    s_vld = vld_o; s_data = data_o; s_last = last_o; s_rdy = rdy_o;
    if (prev_stall) begin
      stall_seen++;
      if (!s_vld || s_data !== prev_data || s_last !== prev_last) stall_viol++;
    end
    prev_stall = s_vld && !r;
    prev_data  = s_data;
    prev_last  = s_last;
    if (s_vld && r) begin
      got_data.push_back(s_data);
      got_last.push_back(s_last);
    end
    acc = v && s_rdy;
    @(posedge clk_i);
  endtask

  // Feed a whole transmission (flush on the final beat) and drain until the last word pops.
  task automatic feed_stream(input bit flags[$], input bit rand_ctl, output bit timed_out);
    int i;
    int cyc;
    bit v, r;
    i = 0; cyc = 0; timed_out = 0;
    got_data.delete(); got_last.delete();
    while (i < flags.size()) begin
      v = rand_ctl ? ($urandom_range(0, 3) != 0) : 1'b1;
      r = rand_ctl ? ($urandom_range(0, 2) != 0) : 1'b1;
      drive_cycle(v, flags[i], i == flags.size() - 1, r);
      if (acc) i++;
      cyc++;
      if (cyc > 5000) begin timed_out = 1; break; end
    end
    while (!timed_out && (got_last.size() == 0 || !got_last[got_last.size()-1])) begin
      r = rand_ctl ? ($urandom_range(0, 2) != 0) : 1'b1;
      drive_cycle(0, 0, 0, r);
      cyc++;
      if (cyc > 6000) timed_out = 1;
    end
    vld_i = 0; flush_i = 0;
  endtask

  // Reference: split flags into symbols (-1 = non-zero, n = run of n zeros), serialise, pad, chunk.
  function automatic void model_encode(input bit flags[$], output logic [DATA_W-1:0] words[$],
                                       output bit lasts[$]);
    int syms[$];
    bit bits[$];
    int run;
    logic [DATA_W-1:0] w;
    run = 0; words = {}; lasts = {};
    foreach (flags[k]) begin
      if (flags[k]) begin
        if (run > 0) syms.push_back(run);
        syms.push_back(-1);
        run = 0;
      end else begin
        run++;
        if (run == MAX_ZRLE_LEN) begin syms.push_back(run); run = 0; end
      end
    end
    if (run > 0) syms.push_back(run);
    foreach (syms[s]) begin
      if (syms[s] < 0) bits.push_back(1);
      else begin
        bits.push_back(0);
        for (int b = LOG_MAX_ZRLE_LEN - 1; b >= 0; b--) bits.push_back(((syms[s] - 1) >> b) & 1);
      end
    end
    while (bits.size() % DATA_W != 0) bits.push_back(0);
    for (int p = 0; p < bits.size(); p += DATA_W) begin
      for (int b = 0; b < DATA_W; b++) w[DATA_W-1-b] = bits[p+b];
      words.push_back(w);
      lasts.push_back(p + DATA_W == bits.size());
    end
  endfunction

  function automatic void model_decode(input logic [DATA_W-1:0] words[$], input int n,
                                       output bit flags[$]);
    bit bits[$];
    int p;
    p = 0; flags = {};
    foreach (words[w]) for (int b = DATA_W - 1; b >= 0; b--) bits.push_back(words[w][b]);
    while (flags.size() < n && p < bits.size()) begin
      if (bits[p]) begin
        flags.push_back(1); p++;
      end else begin
        int len;
        len = 0;
        if (p + LOG_MAX_ZRLE_LEN >= bits.size()) break;
        for (int b = 1; b <= LOG_MAX_ZRLE_LEN; b++) len = len * 2 + bits[p+b];
        p += LOG_MAX_ZRLE_LEN + 1;
        for (int k = 0; k <= len; k++) flags.push_back(0);
      end
    end
  endfunction

  task automatic test_reset();
    rst_ni = 0;
    drive_cycle(0, 0, 0, 1);
    drive_cycle(0, 0, 0, 1);
    n_cmp++; if (s_vld !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_vld got %b want 0", s_vld); end
    n_cmp++; if (s_rdy !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_rdy got %b want 1", s_rdy); end
    n_cmp++; if (s_last !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_last got %b want 0", s_last); end
    n_cmp++; if (s_data !== '0) begin n_bad++; $display("[TB] FAIL reset_data got %h want 00", s_data); end
    rst_ni = 1;
  endtask

  task automatic test_all_ones();
    bit f[$];
    bit to;
    repeat (8) f.push_back(1);
    feed_stream(f, 0, to);
    n_cmp++; if (to !== 1'b0) begin n_bad++; $display("[TB] FAIL ones_timeout got %b want 0", to); end
    n_cmp++;
    if (got_data.size() !== 1) begin
      n_bad++; $display("[TB] FAIL ones_count got %0d want 1", got_data.size());
    end else begin
      n_cmp++; if (got_data[0] !== 8'hFF) begin n_bad++; $display("[TB] FAIL ones_word got %h want ff", got_data[0]); end
      n_cmp++; if (got_last[0] !== 1'b1) begin n_bad++; $display("[TB] FAIL ones_last got %b want 1", got_last[0]); end
    end
  endtask

  task automatic test_short_run();
    bit f[$];
    bit to;
    f = {1'b0, 1'b0, 1'b0, 1'b1};
    feed_stream(f, 0, to);
    n_cmp++;
    if (to || got_data.size() !== 1) begin
      n_bad++; $display("[TB] FAIL short_count got %0d want 1 (timeout %b)", got_data.size(), to);
    end else begin
      n_cmp++; if (got_data[0] !== 8'h14) begin n_bad++; $display("[TB] FAIL short_word got %h want 14", got_data[0]); end
      n_cmp++; if (got_last[0] !== 1'b1) begin n_bad++; $display("[TB] FAIL short_last got %b want 1", got_last[0]); end
    end
  endtask

  task automatic test_max_run();
    bit f[$];
    bit to;
    repeat (16) f.push_back(0);
    feed_stream(f, 0, to);
    n_cmp++;
    if (to || got_data.size() !== 1) begin
      n_bad++; $display("[TB] FAIL maxrun_count got %0d want 1 (timeout %b)", got_data.size(), to);
    end else begin
      n_cmp++; if (got_data[0] !== 8'h78) begin n_bad++; $display("[TB] FAIL maxrun_word got %h want 78", got_data[0]); end
      n_cmp++; if (got_last[0] !== 1'b1) begin n_bad++; $display("[TB] FAIL maxrun_last got %b want 1", got_last[0]); end
    end
  endtask

  task automatic test_run_overflow();
    bit f[$];
    bit to;
    logic [DATA_W-1:0] exp_w[2];
    bit exp_l[2];
    exp_w[0] = 8'h78; exp_w[1] = 8'h00;
    exp_l[0] = 0;     exp_l[1] = 1;
    repeat (17) f.push_back(0);
    feed_stream(f, 0, to);
    n_cmp++;
    if (to || got_data.size() !== 2) begin
      n_bad++; $display("[TB] FAIL ovf_count got %0d want 2 (timeout %b)", got_data.size(), to);
    end else begin
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (got_data[k] !== exp_w[k] || got_last[k] !== exp_l[k]) begin
          n_bad++;
          $display("[TB] FAIL ovf_word%0d got %h/%b want %h/%b", k, got_data[k], got_last[k], exp_w[k], exp_l[k]);
        end
      end
    end
  endtask

  task automatic test_random_stall();
    bit f[$];
    bit dec[$];
    bit to;
    logic [DATA_W-1:0] exp_w[$];
    bit exp_l[$];
    int n, pz;
    stall_viol = 0; stall_seen = 0;
    for (int t = 0; t < 12; t++) begin
      f = {};
      n  = $urandom_range(1, 70);
      pz = $urandom_range(30, 97);
      for (int k = 0; k < n; k++) f.push_back($urandom_range(0, 99) >= pz);
      model_encode(f, exp_w, exp_l);
      feed_stream(f, 1, to);
      n_cmp++;
      if (to || got_data.size() !== exp_w.size()) begin
        n_bad++;
        $display("[TB] FAIL rand%0d_count got %0d want %0d (timeout %b)", t, got_data.size(), exp_w.size(), to);
        continue;
      end
      foreach (exp_w[k]) begin
        n_cmp++;
        if (got_data[k] !== exp_w[k] || got_last[k] !== exp_l[k]) begin
          n_bad++;
          $display("[TB] FAIL rand%0d_word%0d got %h/%b want %h/%b", t, k, got_data[k], got_last[k], exp_w[k], exp_l[k]);
        end
      end
      model_decode(got_data, f.size(), dec);
      n_cmp++;
      if (dec.size() !== f.size()) begin
        n_bad++; $display("[TB] FAIL rand%0d_decode_len got %0d want %0d", t, dec.size(), f.size());
      end else begin
        foreach (f[k]) begin
          n_cmp++;
          if (dec[k] !== f[k]) begin
            n_bad++; $display("[TB] FAIL rand%0d_decode%0d got %b want %b", t, k, dec[k], f[k]);
          end
        end
      end
    end
    n_cmp++; if (stall_viol !== 0) begin n_bad++; $display("[TB] FAIL stall_hold got %0d violations want 0", stall_viol); end
    $display("[TB] random streams done, %0d stalled cycles observed", stall_seen);
  endtask

  task automatic test_reset_mid_word();
    bit pre[8];
    bit f[$];
    bit to;
    pre = '{1, 1, 1, 1, 1, 0, 0, 0};
    got_data.delete(); got_last.delete();
    foreach (pre[k]) drive_cycle(1, pre[k], 0, 1);
    vld_i = 0;
    rst_ni = 0;
    drive_cycle(0, 0, 0, 1);
    rst_ni = 1;
    drive_cycle(0, 0, 0, 1);
    n_cmp++; if (s_vld !== 1'b0) begin n_bad++; $display("[TB] FAIL midreset_vld got %b want 0", s_vld); end
    n_cmp++; if (s_rdy !== 1'b1) begin n_bad++; $display("[TB] FAIL midreset_rdy got %b want 1", s_rdy); end
    repeat (8) f.push_back(1);
    feed_stream(f, 0, to);
    n_cmp++;
    if (to || got_data.size() !== 1) begin
      n_bad++; $display("[TB] FAIL midreset_count got %0d want 1 (timeout %b)", got_data.size(), to);
    end else begin
      n_cmp++;
      if (got_data[0] !== 8'hFF || got_last[0] !== 1'b1) begin
        n_bad++; $display("[TB] FAIL midreset_word got %h/%b want ff/1", got_data[0], got_last[0]);
      end
    end
  endtask

  initial begin
    rst_ni = 0; vld_i = 0; znz_i = 0; flush_i = 0; rdy_i = 1;
    test_reset();
    test_all_ones();
    test_short_run();
    test_max_run();
    test_run_overflow();
    test_random_stall();
    test_reset_mid_word();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
